switch_reader: RTL and testbench

SWITCH_READER -- requirements
Module: switch_reader

---
 rtl/switch_reader.sv | 88 ++++++++
 tb/tb_switch_reader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/switch_reader.sv
// switch_reader: two debounced pushbuttons driving an 8-bit press counter.
// Macro SWITCH_READER_DOWN_EN: sw2 decrements cnt; otherwise sw2 clears cnt.

// switch_debounce: synchronize one raw switch and accept level changes only after DEBOUNCE stable cycles.
module switch_debounce #(
  parameter int DEBOUNCE = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
  logic [1:0]    r_sync;
  state_t        r_state, w_next;
  logic [CW-1:0] r_count, w_count;
  logic          r_press;
  logic          w_in;
  assign w_in  = r_sync[1];
  assign level = (r_state == IDLE_HIGH) || (r_state == WAIT_LOW);
  assign press = r_press;
  // Two-flop synchronizer, debounce state, counter and registered press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_state <= IDLE_LOW;
      r_count <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], sw};
      r_state <= w_next;
      r_count <= w_count;
      r_press <= (r_state == WAIT_HIGH) && (w_next == IDLE_HIGH);
    end
  end
  // Next state: the counter saturates at LAST because reaching it always leaves the wait state.
  always_comb begin
    w_next  = r_state;
    w_count = r_count;
    case (r_state)
      IDLE_LOW:  if (w_in) begin w_next = WAIT_HIGH; w_count = '0; end
      WAIT_HIGH: if (!w_in) begin w_next = IDLE_LOW; w_count = '0; end
                 else if (r_count == LAST) w_next = IDLE_HIGH;
                 else w_count = r_count + 1'b1;
      IDLE_HIGH: if (!w_in) begin w_next = WAIT_LOW; w_count = '0; end
      WAIT_LOW:  if (w_in) begin w_next = IDLE_HIGH; w_count = '0; end
                 else if (r_count == LAST) w_next = IDLE_LOW;
                 else w_count = r_count + 1'b1;
      default:   begin w_next = IDLE_LOW; w_count = '0; end
    endcase
  end
endmodule

module switch_reader #(
  parameter int DEBOUNCE = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw1,
  input  logic       sw2,
  output logic       sw1_level,
  output logic       sw2_level,
  output logic       sw1_press,
  output logic       sw2_press,
  output logic [7:0] cnt
);
  logic [7:0] r_cnt;
  assign cnt = r_cnt;
  switch_debounce #(.DEBOUNCE(DEBOUNCE)) u_sw1 (
    .clk(clk), .rst(rst), .sw(sw1), .level(sw1_level), .press(sw1_press)
  );
  switch_debounce #(.DEBOUNCE(DEBOUNCE)) u_sw2 (
    .clk(clk), .rst(rst), .sw(sw2), .level(sw2_level), .press(sw2_press)
  );
  // Press counter updates the cycle after a pulse; coincident pulses resolve per build option.
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= 8'h00;
`ifdef SWITCH_READER_DOWN_EN
    else r_cnt <= (sw1_press && !sw2_press) ? r_cnt + 8'd1 :
                  (sw2_press && !sw1_press) ? r_cnt - 8'd1 : r_cnt;
`else
    else r_cnt <= sw2_press ? 8'h00 : sw1_press ? r_cnt + 8'd1 : r_cnt;
`endif
  end
endmodule

// File: tb/tb_switch_reader.sv
// tb_switch_reader: scoreboard bench for switch_reader with DEBOUNCE = 4.
module tb_switch_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw1 = 1'b0;
  logic       sw2 = 1'b0;
  logic       sw1_level, sw2_level, sw1_press, sw2_press;
  logic [7:0] cnt;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] m_cnt = 8'h00;
  typedef struct {
    bit         p1;
    bit         p2;
    int         cyc;
    logic [7:0] cnt;
  } exp_t;
  exp_t       q[$];
  bit         pend = 1'b0;
  logic [7:0] pend_cnt = 8'h00;

  switch_reader #(.DEBOUNCE(4)) dut (
    .clk(clk), .rst(rst), .sw1(sw1), .sw2(sw2),
    .sw1_level(sw1_level), .sw2_level(sw2_level),
    .sw1_press(sw1_press), .sw2_press(sw2_press), .cnt(cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected press appears 7 edges after the cycle the raw input is driven (1 sample + DEBOUNCE + 2).
  task automatic push(input bit a, input bit b, input int at);
    exp_t e;
`ifdef SWITCH_READER_DOWN_EN
    m_cnt = (a && !b) ? m_cnt + 8'd1 : (b && !a) ? m_cnt - 8'd1 : m_cnt;
`else
    m_cnt = b ? 8'h00 : a ? m_cnt + 8'd1 : m_cnt;
`endif
    e.p1 = a; e.p2 = b; e.cyc = at; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic press(input bit a, input bit b);
    sw1 = a; sw2 = b;
    push(a, b, cyc + 7);
    tick(10);
    sw1 = 1'b0; sw2 = 1'b0;
    tick(10);
  endtask

  always @(negedge clk) begin
    if (pend) begin
      chk("cnt_after_press", {24'h0, cnt}, {24'h0, pend_cnt});
      pend = 1'b0;
    end
    if (!rst && (sw1_press || sw2_press)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_press: sw1_press=%0b sw2_press=%0b expected none (cycle %0d)", sw1_press, sw2_press, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("press_cycle", cyc, e.cyc);
        chk("press_bits", {30'h0, sw1_press, sw2_press}, {30'h0, e.p1, e.p2});
        pend = 1'b1;
        pend_cnt = e.cnt;
      end
    end
  end

  initial begin
    int s;
    sw1 = 1'b1;
    tick(3);
    chk("rst_sw1_level", {31'h0, sw1_level}, 0);
    chk("rst_sw2_level", {31'h0, sw2_level}, 0);
    chk("rst_sw1_press", {31'h0, sw1_press}, 0);
    chk("rst_sw2_press", {31'h0, sw2_press}, 0);
    chk("rst_cnt", {24'h0, cnt}, 0);
    rst = 1'b0;
    push(1'b1, 1'b0, cyc + 7);
    tick(20);
    chk("held_through_reset_level", {31'h0, sw1_level}, 1);
    sw1 = 1'b0;
    tick(12);
    chk("release_level", {31'h0, sw1_level}, 0);
    sw1 = 1'b1;
    push(1'b1, 1'b0, cyc + 7);
    tick(20);
    chk("step_held_level", {31'h0, sw1_level}, 1);
    sw1 = 1'b0;
    tick(12);
    for (int i = 0; i < 5; i++) begin
      sw1 = 1'b1;
      tick(3);
      chk("glitch_level", {31'h0, sw1_level}, 0);
      sw1 = 1'b0;
      tick(10);
    end
    chk("glitch_cnt", {24'h0, cnt}, {24'h0, m_cnt});
    while (m_cnt != 8'h2A) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("sw2_press_cnt", {24'h0, cnt}, {24'h0, m_cnt});
    press(1'b1, 1'b1);
    chk("coincident_cnt", {24'h0, cnt}, {24'h0, m_cnt});
    while (m_cnt != 8'hFF) press(1'b1, 1'b0);
    chk("cnt_at_ff", {24'h0, cnt}, 32'hFF);
    press(1'b1, 1'b0);
    chk("wrap_up_cnt", {24'h0, cnt}, 0);
    press(1'b0, 1'b1);
    chk("sw2_from_zero_cnt", {24'h0, cnt}, {24'h0, m_cnt});
    sw1 = 1'b1;
    tick(6);
    rst = 1'b1;
    tick(1);
    m_cnt = 8'h00;
    chk("midflight_rst_press", {31'h0, sw1_press}, 0);
    chk("midflight_rst_level", {31'h0, sw1_level}, 0);
    chk("midflight_rst_cnt", {24'h0, cnt}, 0);
    tick(1);
    rst = 1'b0;
    push(1'b1, 1'b0, cyc + 7);
    tick(10);
    sw1 = 1'b0;
    tick(12);
    chk("queue_drained", q.size(), 0);
    chk("final_cnt", {24'h0, cnt}, {24'h0, m_cnt});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
